// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FPU opcode encodings, error/requester widths and small helpers
package cpu_pkg;
  localparam int FPU_OPE_W = 4;
  localparam int FPU_ERR_W = 3;
  localparam int REQ_ID_W = 1;
  typedef enum logic [FPU_OPE_W-1:0] {
    FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_MIN,
    FPU_MAX, FPU_CVT_WS, FPU_CVT_SW, FPU_FEQ, FPU_FLT, FPU_FLE
  } fpu_ope_e;
  typedef logic [REQ_ID_W-1:0] req_id_t;
  function automatic logic fpu_ope_ok(input logic [FPU_OPE_W-1:0] ope);
    return ope <= FPU_OPE_W'(FPU_FLE);
  endfunction
endpackage

// File: rtl/fpu_tag_fifo.sv
// fpu_tag_fifo: in-order FIFO of requester ids for ops issued to the shared FPU
module fpu_tag_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  req_id_t                  tag_i,
  input  logic                     pop_i,
  output req_id_t                  head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  req_id_t         mem_q [DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  // push and pop together leave the occupancy unchanged
  always_comb cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  // pointers are exactly log2(DEPTH) bits so they wrap without explicit compare
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= tag_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop_i) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fpu_share_arb.sv
// fpu_share_arb: round-robin sharing of one pipelined FPU between two requesters
module fpu_share_arb
  import cpu_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [FPU_OPE_W-1:0] rq_ope_0,
  input  logic [31:0]          rq_in1_0,
  input  logic [31:0]          rq_in2_0,
  input  logic                 rq_in_vld_0,
  output logic                 rq_in_rdy_0,
  output logic [31:0]          rq_out_data_0,
  output logic                 rq_out_vld_0,
  input  logic                 rq_out_rdy_0,
  output logic [FPU_ERR_W-1:0] rq_err_0,
  input  logic                 rq_err_clr_0,
  input  logic [FPU_OPE_W-1:0] rq_ope_1,
  input  logic [31:0]          rq_in1_1,
  input  logic [31:0]          rq_in2_1,
  input  logic                 rq_in_vld_1,
  output logic                 rq_in_rdy_1,
  output logic [31:0]          rq_out_data_1,
  output logic                 rq_out_vld_1,
  input  logic                 rq_out_rdy_1,
  output logic [FPU_ERR_W-1:0] rq_err_1,
  input  logic                 rq_err_clr_1,
  output logic [FPU_OPE_W-1:0] f_ope_data,
  output logic [31:0]          f_in1_data,
  output logic [31:0]          f_in2_data,
  output logic                 f_in_vld,
  input  logic                 f_in_rdy,
  input  logic [31:0]          f_out_data,
  input  logic                 f_out_vld,
  output logic                 f_out_rdy,
  input  logic [FPU_ERR_W-1:0] f_err,
  output logic                 orphan_err
);
  localparam int CW = $clog2(MAX_OUT) + 1;
  logic [FPU_OPE_W-1:0] f_ope_q;
  logic [31:0]          f_in1_q, f_in2_q;
  logic                 f_in_vld_q;
  req_id_t              last_q;
  logic [FPU_ERR_W-1:0] err0_q, err0_d, err1_q, err1_d;
  logic                 orphan_q, orphan_d;
  logic                 issue_busy, full, elig0, elig1, gnt0, gnt1, push, pop, nonempty;
  logic                 head_is0, head_is1;
  req_id_t              head;
  logic [CW-1:0]        count;
  // full uses the registered count so a same-cycle pop never opens a slot early
  assign issue_busy = f_in_vld_q & ~f_in_rdy;
  assign full       = count == CW'(MAX_OUT);
  assign elig0      = rq_in_vld_0 & ~issue_busy & ~full;
  assign elig1      = rq_in_vld_1 & ~issue_busy & ~full;
  assign gnt0       = elig0 & (~elig1 | last_q == req_id_t'(1));
  assign gnt1       = elig1 & (~elig0 | last_q == req_id_t'(0));
  assign push       = gnt0 | gnt1;
  assign rq_in_rdy_0 = gnt0;
  assign rq_in_rdy_1 = gnt1;
  // results return in issue order; the head tag alone decides who sees them
  assign nonempty      = count != '0;
  assign head_is0      = head == req_id_t'(0);
  assign head_is1      = head == req_id_t'(1);
  assign rq_out_vld_0  = f_out_vld & nonempty & head_is0;
  assign rq_out_vld_1  = f_out_vld & nonempty & head_is1;
  assign rq_out_data_0 = f_out_data;
  assign rq_out_data_1 = f_out_data;
  assign f_out_rdy     = nonempty & (head_is1 ? rq_out_rdy_1 : rq_out_rdy_0);
  assign pop           = f_out_vld & f_out_rdy;
  fpu_tag_fifo #(.DEPTH(MAX_OUT)) u_tags (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .tag_i   (req_id_t'(gnt1)),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );
  // clear first, then OR in a completing error so a coincident error survives the clear
  always_comb begin
    err0_d   = (rq_err_clr_0 ? '0 : err0_q) | ((pop & head_is0) ? f_err : '0);
    err1_d   = (rq_err_clr_1 ? '0 : err1_q) | ((pop & head_is1) ? f_err : '0);
    orphan_d = orphan_q | (f_out_vld & ~nonempty);
  end
  // operand register: load on grant, drop valid once the FPU has taken it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f_ope_q    <= '0;
      f_in1_q    <= '0;
      f_in2_q    <= '0;
      f_in_vld_q <= 1'b0;
      last_q     <= req_id_t'(1);
    end else if (push) begin
      f_ope_q    <= gnt1 ? rq_ope_1 : rq_ope_0;
      f_in1_q    <= gnt1 ? rq_in1_1 : rq_in1_0;
      f_in2_q    <= gnt1 ? rq_in2_1 : rq_in2_0;
      f_in_vld_q <= 1'b1;
      last_q     <= req_id_t'(gnt1);
    end else if (f_in_rdy) begin
      f_in_vld_q <= 1'b0;
    end
  end
  // sticky per-requester and orphan error status
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err0_q   <= '0;
      err1_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      orphan_q <= orphan_d;
    end
  end
  assign f_ope_data = f_ope_q;
  assign f_in1_data = f_in1_q;
  assign f_in2_data = f_in2_q;
  assign f_in_vld   = f_in_vld_q;
  assign rq_err_0   = err0_q;
  assign rq_err_1   = err1_q;
  assign orphan_err = orphan_q;
endmodule
